// File: rtl/nonbin_class_updater.sv
// nonbin_class_updater
//
// Adds (op_sub=0) or subtracts (op_sub=1) a binary query hypervector to or from a held
// non-binary class hypervector. Both are streamed one segment at a time. Every dimension
// saturates at the two's-complement limits of BITWIDTH_PER_DIM, and clipped updates are counted.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   start, op_sub               one-cycle update request and its operation (sampled in idle)
//   query_valid, query_seg      query segment handshake in (bit 1 = +1, bit 0 = -1)
//   query_ready                 query segment accepted when valid && ready
//   nonbin_class_reg_out        class register segment selected by class_ctr
//   class_ctr, nonbin_ctr       read / write segment select (both equal the current segment)
//   adjusting_nonbin_class_hvs  class register write enable
//   nonbin_class_reg_in         updated segment to write back
//   busy, done                  operation in flight / one-cycle completion pulse
//   sat_cnt                     clipped dimension updates during the last operation
module nonbin_class_updater #(
  parameter int unsigned DIMS_PER_CC      = 1024,
  parameter int unsigned BITWIDTH_PER_DIM = 9,
  parameter int unsigned SEQ_CYCLE_COUNT  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   op_sub,
  input  logic                                   query_valid,
  input  logic [DIMS_PER_CC-1:0]                 query_seg,
  output logic                                   query_ready,
  input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] nonbin_class_reg_out,
  output logic [1:0]                             class_ctr,
  output logic [1:0]                             nonbin_ctr,
  output logic                                   adjusting_nonbin_class_hvs,
  output logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] nonbin_class_reg_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [12:0]                            sat_cnt
);

  localparam int unsigned W     = BITWIDTH_PER_DIM;
  localparam int unsigned SegW  = DIMS_PER_CC * BITWIDTH_PER_DIM;
  localparam int unsigned ClipW = $clog2(DIMS_PER_CC + 1);
  localparam int unsigned SatW  = 13;

  localparam logic [1:0]   LastSeg = 2'(SEQ_CYCLE_COUNT - 1);
  localparam logic [W-1:0] DimMax  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] DimMin  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StWaitQ, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      seg_q, seg_d;
  logic            op_q, op_d;
  logic [SegW-1:0] result_q, result_d;
  logic [SatW-1:0] sat_q, sat_d;

  // Segment datapath: +/-1 per dimension, held at the rail instead of wrapping.
  logic [SegW-1:0]  upd;
  logic [ClipW-1:0] clip_sum;
  logic [W-1:0]     dim;
  logic             inc;

  always_comb begin
    upd      = '0;
    clip_sum = '0;
    dim      = '0;
    inc      = 1'b0;
    for (int d = 0; d < DIMS_PER_CC; d++) begin
      dim = nonbin_class_reg_out[d*W +: W];
      inc = query_seg[d] ^ op_q;
      if ((inc && dim == DimMax) || (!inc && dim == DimMin)) begin
        upd[d*W +: W] = dim;
        clip_sum      = clip_sum + ClipW'(1);
      end else begin
        upd[d*W +: W] = inc ? dim + W'(1) : dim - W'(1);
      end
    end
  end

  // Running clip count; pinned at all-ones rather than wrapping for oversized configurations.
  logic [SatW:0]   sat_sum;
  logic [SatW-1:0] sat_next;

  always_comb begin
    sat_sum  = {1'b0, sat_q} + (SatW+1)'(clip_sum);
    sat_next = sat_sum[SatW] ? {SatW{1'b1}} : sat_sum[SatW-1:0];
  end

  always_comb begin
    state_d                    = state_q;
    seg_d                      = seg_q;
    op_d                       = op_q;
    result_d                   = result_q;
    sat_d                      = sat_q;
    query_ready                = 1'b0;
    adjusting_nonbin_class_hvs = 1'b0;
    busy                       = 1'b1;
    done                       = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          op_d    = op_sub;
          seg_d   = 2'd0;
          sat_d   = '0;
          state_d = StWaitQ;
        end
      end
      StWaitQ: begin
        query_ready = 1'b1;
        if (query_valid) begin
          result_d = upd;
          sat_d    = sat_next;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        adjusting_nonbin_class_hvs = 1'b1;
        if (seg_q == LastSeg) begin
          state_d = StDone;
        end else begin
          seg_d   = seg_q + 2'd1;
          state_d = StWaitQ;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      seg_q    <= 2'd0;
      op_q     <= 1'b0;
      result_q <= '0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      op_q     <= op_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign class_ctr           = seg_q;
  assign nonbin_ctr          = seg_q;
  assign nonbin_class_reg_in = result_q;
  assign sat_cnt             = sat_q;

endmodule

// File: tb/tb_nonbin_class_updater.sv
module tb_nonbin_class_updater;

  localparam int D    = 1024;
  localparam int W    = 9;
  localparam int S    = 4;
  localparam int SEGW = D * W;
  localparam int HI   = (1 << (W - 1)) - 1;
  localparam int LO   = -(1 << (W - 1));

  typedef logic [SEGW-1:0] seg_t;
  typedef logic [D-1:0]    q_t;
  typedef struct {
    int   idx;
    seg_t data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, op_sub, query_valid;
  q_t          query_seg;
  logic        query_ready;
  seg_t        reg_out, reg_in;
  logic [1:0]  class_ctr, nonbin_ctr;
  logic        adj, busy, done;
  logic [12:0] sat_cnt;

  nonbin_class_updater #(
    .DIMS_PER_CC     (D),
    .BITWIDTH_PER_DIM(W),
    .SEQ_CYCLE_COUNT (S)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .op_sub                    (op_sub),
    .query_valid               (query_valid),
    .query_seg                 (query_seg),
    .query_ready               (query_ready),
    .nonbin_class_reg_out      (reg_out),
    .class_ctr                 (class_ctr),
    .nonbin_ctr                (nonbin_ctr),
    .adjusting_nonbin_class_hvs(adj),
    .nonbin_class_reg_in       (reg_in),
    .busy                      (busy),
    .done                      (done),
    .sat_cnt                   (sat_cnt)
  );

  always #5 clk = ~clk;

  // Class register the DUT reads and writes back into.
  seg_t class_mem [S];
  seg_t ld_mem    [S];
  logic ld_en = 1'b0;

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < S; i++) class_mem[i] <= ld_mem[i];
    end else if (adj) begin
      class_mem[nonbin_ctr] <= reg_in;
    end
  end

  assign reg_out = class_mem[class_ctr];

  // Reference model state and scoreboard.
  seg_t ref_mem [S];
  q_t   qs      [S];
  int   gaps    [S];
  wr_t  exp_q   [$];
  int   exp_sat_q[$];
  int   checks = 0, errors = 0, n_writes = 0, n_dones = 0;
  bit   op_cur;
  int   exp_sat_acc;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_seg(string name, seg_t act, seg_t exp);
    int first = -1;
    int nd    = 0;
    logic signed [W-1:0] a, e;
    for (int d = 0; d < D; d++) begin
      if (act[d*W +: W] !== exp[d*W +: W]) begin
        nd++;
        if (first < 0) first = d;
      end
    end
    checks++;
    if (nd > 0) begin
      errors++;
      a = act[first*W +: W];
      e = exp[first*W +: W];
      $display("FAIL %s: %0d dims differ, dim %0d got %0d expected %0d", name, nd, first,
               a, e);
    end
  endtask

  // Integer-level model of one segment update.
  function automatic seg_t model_seg(seg_t cur, q_t q, bit op, output int clips);
    seg_t r;
    int v;
    logic signed [W-1:0] x;
    clips = 0;
    r     = '0;
    for (int d = 0; d < D; d++) begin
      x = cur[d*W +: W];
      v = int'(x);
      if (q[d] ^ op) v = v + 1;
      else v = v - 1;
      if (v > HI) begin
        v = HI;
        clips++;
      end else if (v < LO) begin
        v = LO;
        clips++;
      end
      r[d*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  // Monitor: every write and every done pulse is checked against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (adj) begin
          n_writes++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("write_seg_idx", nonbin_ctr, e.idx);
            chk_seg("write_data", reg_in, e.data);
          end
        end
        if (done) begin
          n_dones++;
          if (exp_sat_q.size() == 0) chk("unexpected_done", 1, 0);
          else chk("sat_cnt_at_done", sat_cnt, exp_sat_q.pop_front());
        end
      end
    end
  end

  // mode 0: all 0, 1: all max, 2: all min, 3: random biased toward the rails
  task automatic load_mem(int mode);
    int v;
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        case (mode)
          0: v = 0;
          1: v = HI;
          2: v = LO;
          default: begin
            case ($urandom_range(0, 5))
              0: v = HI;
              1: v = LO;
              2: v = HI - 1;
              3: v = LO + 1;
              default: v = int'($urandom_range(0, 511)) - 256;
            endcase
          end
        endcase
        ld_mem[s][d*W +: W] = v[W-1:0];
      end
      ref_mem[s] = ld_mem[s];
    end
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic set_stim(bit rand_q, int max_gap);
    for (int s = 0; s < S; s++) begin
      for (int k = 0; k < D / 32; k++) qs[s][k*32 +: 32] = rand_q ? $urandom() : 32'hffff_ffff;
      gaps[s] = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    end
  endtask

  task automatic check_mem();
    for (int s = 0; s < S; s++) chk_seg("class_mem_seg", class_mem[s], ref_mem[s]);
  endtask

  task automatic issue_seg(int s, bit poke);
    seg_t e;
    int   c;
    bit   ok = 0;
    if (poke) begin
      start  = 1'b1;
      op_sub = !op_cur;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op_sub = op_cur;
    end
    if (gaps[s] > 0) begin
      query_valid = 1'b0;
      for (int i = 0; i < gaps[s]; i++) begin
        @(negedge clk);
        if (i > 0) begin
          chk("hold_ready", query_ready, 1);
          chk("hold_class_ctr", class_ctr, s);
          chk("hold_no_write", adj, 0);
        end
        @(posedge clk);
        #1;
      end
    end
    e = model_seg(ref_mem[s], qs[s], op_cur, c);
    ref_mem[s]  = e;
    exp_sat_acc += c;
    exp_q.push_back('{s, e});
    query_seg   = qs[s];
    query_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (query_ready) begin
        ok = 1;
        chk("class_ctr_wait", class_ctr, s);
        chk("busy_wait", busy, 1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_op(bit op, int poke_seg, int abort_seg);
    int  w0 = n_writes;
    int  d0 = n_dones;
    time t0, t1;
    bit  got = 0;
    bit  plain = (poke_seg < 0);
    @(posedge clk);
    #1;
    start       = 1'b1;
    op_sub      = op;
    op_cur      = op;
    exp_sat_acc = 0;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
    for (int s = 0; s < S; s++) begin
      if (s == abort_seg) begin
        query_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", query_ready, 0);
        chk("abort_class_ctr", class_ctr, 0);
        chk("abort_nonbin_ctr", nonbin_ctr, 0);
        chk("abort_adjusting", adj, 0);
        chk("abort_done", done, 0);
        chk("abort_sat_cnt", sat_cnt, 0);
        chk_seg("abort_result", reg_in, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_write_count", n_writes - w0, s);
        chk("abort_done_count", n_dones - d0, 0);
        return;
      end
      if (gaps[s] != 0) plain = 0;
      issue_seg(s, s == poke_seg);
    end
    exp_sat_q.push_back(exp_sat_acc);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        t1  = $time;
        break;
      end
    end
    query_valid = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else if (plain) begin
      chk("latency_cycles", longint'((t1 - t0 + 5) / 10 + 1), 2 * S + 2);
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", query_ready, 0);
    chk("idle_sat_hold", sat_cnt, exp_sat_acc);
    chk("op_write_count", n_writes - w0, S);
    chk("op_done_count", n_dones - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    op_sub      = 1'b0;
    query_valid = 1'b0;
    query_seg   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", query_ready, 0);
    chk("rst_class_ctr", class_ctr, 0);
    chk("rst_nonbin_ctr", nonbin_ctr, 0);
    chk("rst_adjusting", adj, 0);
    chk("rst_done", done, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk_seg("rst_result", reg_in, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero class, add all-ones: every dimension becomes +1.
    load_mem(0);
    set_stim(0, 0);
    run_op(0, -1, -1);
    check_mem();
    chk("zero_add_sat", sat_cnt, 0);

    // Positive rail: add clips everything, subtract clips nothing.
    load_mem(1);
    run_op(0, -1, -1);
    check_mem();
    chk("max_add_sat", sat_cnt, 4096);
    load_mem(1);
    run_op(1, -1, -1);
    check_mem();
    chk("max_sub_sat", sat_cnt, 0);

    // Negative rail with subtract.
    load_mem(2);
    run_op(1, -1, -1);
    check_mem();
    chk("min_sub_sat", sat_cnt, 4096);

    // Valid withheld before segment 2.
    load_mem(3);
    set_stim(1, 0);
    gaps[2] = 5;
    run_op(0, -1, -1);
    check_mem();

    // Start re-pulsed with the opposite op while busy.
    load_mem(3);
    set_stim(1, 0);
    run_op(1, 1, -1);
    check_mem();

    // Reset in segment 2 wait: segments 0-1 written, 2-3 untouched.
    load_mem(3);
    set_stim(1, 0);
    run_op(0, -1, 2);
    check_mem();

    for (int n = 0; n < 10; n++) begin
      load_mem(3);
      set_stim(1, 3);
      run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 2 : -1, -1);
      check_mem();
    end

    chk("leftover_writes", exp_q.size(), 0);
    chk("leftover_dones", exp_sat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
